// File: rtl/pcpu_irq_pkg.sv
// Shared definitions for the parametrised interrupt controller.
//   - Register word offsets on the a/d/we/spo bus
//   - FSM state encoding (also visible through STATUS[1:0])
//   - Bit position of the valid flag in the CLAIM register
package pcpu_irq_pkg;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_CLAIM   = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_IN_SERVICE = 2'd2
  } irq_state_e;

  localparam int CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/irq_controller_n_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req_i wins.
// Ports:
//   req_i  [N-1:0]    request vector
//   any_o             at least one request is set
//   id_o   [ID_W-1:0] index of the lowest set request (0 when none)
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 5
) (
  input  logic [N-1:0]    req_i,
  output logic            any_o,
  output logic [ID_W-1:0] id_o
);

  // Scanning from the top down lets the lowest index overwrite last.
  always_comb begin
    any_o = |req_i;
    id_o  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller_n.sv
// N-source interrupt controller with edge/level sources, fixed lowest-index
// priority and an eip / eip_istimer / eip_reply style CPU handshake.
// Further interrupts are held off until software writes CLAIM (EOI).
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   i_irq [N_IRQ-1:0] source request lines (synchronous to clk)
//   a, d, we          register bus: word address, write data, write strobe
//   spo               combinational read data for address a
//   interrupt         interrupt request to the CPU
//   int_istimer       the delivered source is TIMER_IDX
//   int_reply         one-cycle pulse: CPU has taken the trap
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | nothing delivered; waiting for an eligible source
// ST_ASSERT     | interrupt high for cur_id; waiting for int_reply
// ST_IN_SERVICE | CPU is handling cur_id; waiting for the EOI write
module irq_controller_n
  import pcpu_irq_pkg::*;
#(
  parameter int N_IRQ     = 8,
  parameter int TIMER_IDX = 0,
  parameter int ID_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic [2:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo,
  output logic             interrupt,
  output logic             int_istimer,
  input  logic             int_reply
);

  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] enable_q, mode_q, prev_irq_q;
  logic             ctrl_q;
  irq_state_e       state_q;
  logic [ID_W-1:0]  cur_id_q, claim_id_q;
  logic             claim_valid_q, interrupt_q, istimer_q;

  logic [N_IRQ-1:0] eligible, cur_onehot, rise, w1c, edge_clr;
  logic             cur_eligible, eoi, take;
  logic             prio_any;
  logic [ID_W-1:0]  prio_id;
  logic             unused_d;

  assign unused_d = ^d;

  assign eligible     = pending_q & enable_q & {N_IRQ{ctrl_q}};
  assign cur_onehot   = N_IRQ'(1) << cur_id_q;
  assign cur_eligible = |(eligible & cur_onehot);
  assign eoi          = we && (a == REG_CLAIM);
  assign take         = (state_q == ST_ASSERT) && int_reply;

  irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_prio (
    .req_i (eligible),
    .any_o (prio_any),
    .id_o  (prio_id)
  );

  // Edge bits: a new rising edge beats both the software W1C and the
  // clear-on-claim. Level bits just track the registered input.
  assign rise     = i_irq & ~prev_irq_q;
  assign w1c      = (we && (a == REG_PENDING)) ? d[N_IRQ-1:0] : '0;
  assign edge_clr = w1c | (take ? cur_onehot : '0);
  assign pending_d = (mode_q & ((pending_q & ~edge_clr) | rise))
                   | (~mode_q & i_irq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      ctrl_q     <= 1'b0;
      prev_irq_q <= '0;
    end else begin
      pending_q  <= pending_d;
      prev_irq_q <= i_irq;
      if (we && (a == REG_ENABLE)) enable_q <= d[N_IRQ-1:0];
      if (we && (a == REG_MODE))   mode_q   <= d[N_IRQ-1:0];
      if (we && (a == REG_CTRL))   ctrl_q   <= d[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cur_id_q      <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      interrupt_q   <= 1'b0;
      istimer_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (prio_any) begin
            cur_id_q    <= prio_id;
            state_q     <= ST_ASSERT;
            interrupt_q <= 1'b1;
            istimer_q   <= (prio_id == ID_W'(TIMER_IDX));
          end
        end
        ST_ASSERT: begin
          if (int_reply) begin
            claim_valid_q <= 1'b1;
            claim_id_q    <= cur_id_q;
            state_q       <= ST_IN_SERVICE;
            interrupt_q   <= 1'b0;
            istimer_q     <= 1'b0;
          end else if (!cur_eligible) begin
            // No preemption: only the loss of cur_id itself withdraws.
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
            istimer_q   <= 1'b0;
          end
        end
        ST_IN_SERVICE: begin
          if (eoi) begin
            claim_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          interrupt_q <= 1'b0;
          istimer_q   <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt   = interrupt_q;
  assign int_istimer = istimer_q;

  always_comb begin
    spo = '0;
    case (a)
      REG_PENDING: spo = 32'(pending_q);
      REG_ENABLE:  spo = 32'(enable_q);
      REG_MODE:    spo = 32'(mode_q);
      REG_CLAIM: begin
        spo                  = 32'(claim_id_q);
        spo[CLAIM_VALID_BIT] = claim_valid_q;
      end
      REG_CTRL:    spo = {31'b0, ctrl_q};
      REG_STATUS:  spo = {23'b0, interrupt_q, 6'b0, state_q};
      default:     spo = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller_n.sv
module tb_irq_controller_n;
  localparam int N_IRQ     = 8;
  localparam int TIMER_IDX = 0;
  localparam int ID_W      = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_irq = '0;
  logic [2:0]  a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic        int_reply = 1'b0;
  logic [31:0] spo;
  logic        interrupt, int_istimer;

  int checks = 0;
  int failures = 0;

  irq_controller_n #(.N_IRQ(N_IRQ), .TIMER_IDX(TIMER_IDX), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .i_irq(i_irq), .a(a), .d(d), .we(we),
    .spo(spo), .interrupt(interrupt), .int_istimer(int_istimer),
    .int_reply(int_reply)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: per-source rules and a 3-phase handshake
  // (0 idle, 1 requesting, 2 in service) evaluated once per clock.
  logic [7:0] m_pend = '0, m_prev = '0, m_en = '0, m_mode = '0;
  logic       m_gen = 1'b0, m_int = 1'b0, m_tmr = 1'b0, m_cvalid = 1'b0;
  int         m_phase = 0, m_cur = 0, m_cid = 0;
  logic [7:0] m_elig, m_np;
  int         m_low;
  logic       m_taken, m_set, m_clr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = '0; m_prev = '0; m_en = '0; m_mode = '0; m_gen = 1'b0;
      m_int = 1'b0; m_tmr = 1'b0; m_cvalid = 1'b0;
      m_phase = 0; m_cur = 0; m_cid = 0;
    end else begin
      m_elig = m_gen ? (m_pend & m_en) : 8'h00;
      m_low = -1;
      for (int i = 0; i < 8; i++) if (m_low < 0 && m_elig[i]) m_low = i;
      m_taken = 1'b0;
      if (m_phase == 0) begin
        if (m_low >= 0) begin
          m_cur = m_low; m_phase = 1; m_int = 1'b1; m_tmr = (m_low == TIMER_IDX);
        end
      end else if (m_phase == 1) begin
        if (int_reply) begin
          m_cvalid = 1'b1; m_cid = m_cur; m_taken = 1'b1;
          m_phase = 2; m_int = 1'b0; m_tmr = 1'b0;
        end else if (!m_elig[m_cur]) begin
          m_phase = 0; m_int = 1'b0; m_tmr = 1'b0;
        end
      end else begin
        if (we && a == 3'd3) begin
          m_cvalid = 1'b0; m_phase = 0;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (m_mode[i]) begin
          m_set = i_irq[i] && !m_prev[i];
          m_clr = (we && a == 3'd0 && d[i]) || (m_taken && m_cur == i);
          m_np[i] = m_set ? 1'b1 : (m_clr ? 1'b0 : m_pend[i]);
        end else begin
          m_np[i] = i_irq[i];
        end
      end
      m_pend = m_np;
      if (we && a == 3'd1) m_en = d[7:0];
      if (we && a == 3'd2) m_mode = d[7:0];
      if (we && a == 3'd4) m_gen = d[0];
      m_prev = i_irq;
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] ad);
    case (ad)
      3'd0: return {24'b0, m_pend};
      3'd1: return {24'b0, m_en};
      3'd2: return {24'b0, m_mode};
      3'd3: return {m_cvalid, 26'b0, 5'(m_cid)};
      3'd4: return {31'b0, m_gen};
      3'd5: return {23'b0, m_int, 6'b0, 2'(m_phase)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ad, input logic [31:0] dat);
    a = ad; d = dat; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic reply();
    int_reply = 1'b1;
    cyc();
    int_reply = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_interrupt got=%0b exp=0", interrupt); end
    checks++; if (int_istimer !== 1'b0) begin failures++; $display("FAIL reset_istimer got=%0b exp=0", int_istimer); end
    for (int r = 0; r < 8; r++) begin
      a = 3'(r); #1;
      checks++; if (spo !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", r, spo); end
    end
    #4 rst = 1'b1;
    cyc();
  endtask

  task automatic test_edge_delivery();
    wr(3'd1, 32'h08); wr(3'd2, 32'h08); wr(3'd4, 32'h1);
    i_irq[3] = 1'b1;
    cyc();
    i_irq[3] = 1'b0;
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL edge_early got=%0b exp=0", interrupt); end
    cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL edge_latency got=%0b exp=1", interrupt); end
    a = 3'd5; #1;
    checks++; if (spo !== 32'h101) begin failures++; $display("FAIL edge_status_assert got=%h exp=101", spo); end
    reply();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL edge_int_after_reply got=%0b exp=0", interrupt); end
    a = 3'd3; #1;
    checks++; if (spo !== 32'h80000003) begin failures++; $display("FAIL edge_claim got=%h exp=80000003", spo); end
    a = 3'd0; #1;
    checks++; if (spo[3] !== 1'b0) begin failures++; $display("FAIL edge_pending_cleared got=%0b exp=0", spo[3]); end
    wr(3'd3, 32'h0);
    a = 3'd5; #1;
    checks++; if (spo !== 32'h0) begin failures++; $display("FAIL edge_status_after_eoi got=%h exp=0", spo); end
    a = 3'd3; #1;
    checks++; if (spo[31] !== 1'b0) begin failures++; $display("FAIL edge_claim_valid_after_eoi got=%0b exp=0", spo[31]); end
    cyc(); cyc();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL edge_quiet_after_eoi got=%0b exp=0", interrupt); end
  endtask

  task automatic test_priority();
    logic [31:0] exp_ids [3];
    exp_ids[0] = 32'h80000001; exp_ids[1] = 32'h80000005; exp_ids[2] = 32'h0;
    wr(3'd1, 32'h26); wr(3'd2, 32'h26);
    i_irq = 8'h24;
    cyc();
    i_irq = 8'h00;
    cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL prio_first_int got=%0b exp=1", interrupt); end
    reply();
    a = 3'd3; #1;
    checks++; if (spo !== 32'h80000002) begin failures++; $display("FAIL prio_first_claim got=%h exp=80000002", spo); end
    i_irq[1] = 1'b1;
    cyc();
    i_irq[1] = 1'b0;
    cyc();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL prio_no_preempt got=%0b exp=0", interrupt); end
    a = 3'd0; #1;
    checks++; if (spo !== 32'h22) begin failures++; $display("FAIL prio_pending got=%h exp=22", spo); end
    for (int k = 0; k < 2; k++) begin
      wr(3'd3, 32'h0);
      cyc();
      checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL prio_b2b_int%0d got=%0b exp=1", k, interrupt); end
      reply();
      a = 3'd3; #1;
      checks++; if (spo !== exp_ids[k]) begin failures++; $display("FAIL prio_claim%0d got=%h exp=%h", k, spo, exp_ids[k]); end
    end
    wr(3'd3, 32'h0);
    a = 3'd0; #1;
    checks++; if (spo !== exp_ids[2]) begin failures++; $display("FAIL prio_pending_drained got=%h exp=0", spo); end
  endtask

  task automatic test_level_withdraw();
    wr(3'd2, 32'h0); wr(3'd1, 32'h10);
    i_irq[4] = 1'b1;
    cyc(); cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL lvl_assert got=%0b exp=1", interrupt); end
    i_irq[4] = 1'b0;
    cyc(); cyc();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL lvl_withdraw got=%0b exp=0", interrupt); end
    a = 3'd5; #1;
    checks++; if (spo !== 32'h0) begin failures++; $display("FAIL lvl_withdraw_status got=%h exp=0", spo); end
    a = 3'd3; #1;
    checks++; if (spo[31] !== 1'b0) begin failures++; $display("FAIL lvl_withdraw_claim got=%0b exp=0", spo[31]); end
  endtask

  task automatic test_level_refire();
    i_irq[4] = 1'b1;
    cyc(); cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL refire_first got=%0b exp=1", interrupt); end
    reply();
    a = 3'd3; #1;
    checks++; if (spo !== 32'h80000004) begin failures++; $display("FAIL refire_claim1 got=%h exp=80000004", spo); end
    wr(3'd3, 32'h0);
    cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL refire_after_eoi got=%0b exp=1", interrupt); end
    reply();
    a = 3'd3; #1;
    checks++; if (spo !== 32'h80000004) begin failures++; $display("FAIL refire_claim2 got=%h exp=80000004", spo); end
    i_irq[4] = 1'b0;
    wr(3'd3, 32'h0);
    cyc(); cyc();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL refire_stops got=%0b exp=0", interrupt); end
  endtask

  task automatic test_timer_setwins();
    wr(3'd1, 32'h01); wr(3'd2, 32'h01);
    i_irq[0] = 1'b1;
    cyc();
    i_irq[0] = 1'b0;
    cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL timer_int got=%0b exp=1", interrupt); end
    checks++; if (int_istimer !== 1'b1) begin failures++; $display("FAIL timer_flag got=%0b exp=1", int_istimer); end
    reply();
    checks++; if (int_istimer !== 1'b0) begin failures++; $display("FAIL timer_flag_drop got=%0b exp=0", int_istimer); end
    a = 3'd3; #1;
    checks++; if (spo !== 32'h80000000) begin failures++; $display("FAIL timer_claim got=%h exp=80000000", spo); end
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h0);
    i_irq[0] = 1'b1;
    wr(3'd0, 32'h1);
    i_irq[0] = 1'b0;
    a = 3'd0; #1;
    checks++; if (spo[0] !== 1'b1) begin failures++; $display("FAIL set_wins got=%0b exp=1", spo[0]); end
    wr(3'd0, 32'h1);
    a = 3'd0; #1;
    checks++; if (spo[0] !== 1'b0) begin failures++; $display("FAIL w1c_clears got=%0b exp=0", spo[0]); end
    wr(3'd4, 32'h1);
  endtask

  task automatic test_async_reset();
    i_irq[0] = 1'b1;
    cyc();
    i_irq[0] = 1'b0;
    cyc();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b exp=1", interrupt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL areset_interrupt got=%0b exp=0", interrupt); end
    checks++; if (int_istimer !== 1'b0) begin failures++; $display("FAIL areset_istimer got=%0b exp=0", int_istimer); end
    for (int r = 0; r < 8; r++) begin
      a = 3'(r); #1;
      checks++; if (spo !== 32'h0) begin failures++; $display("FAIL areset_reg%0d got=%h exp=0", r, spo); end
    end
    #3 rst = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    logic [2:0] ra;
    logic [31:0] exp_rd;
    wr(3'd1, 32'hFF); wr(3'd2, $urandom); wr(3'd4, 32'h1);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 7) == 0) i_irq[i] = ~i_irq[i];
      int_reply = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        we = 1'b1; a = 3'($urandom_range(0, 7)); d = $urandom;
        if (a == 3'd4 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      end else begin
        we = 1'b0;
      end
      cyc();
      we = 1'b0;
      checks++; if (interrupt !== m_int) begin failures++; $display("FAIL rnd_interrupt cyc=%0d got=%0b exp=%0b", n, interrupt, m_int); end
      checks++; if (int_istimer !== m_tmr) begin failures++; $display("FAIL rnd_istimer cyc=%0d got=%0b exp=%0b", n, int_istimer, m_tmr); end
      ra = 3'($urandom_range(0, 7));
      a = ra; #1;
      exp_rd = m_read(ra);
      checks++; if (spo !== exp_rd) begin failures++; $display("FAIL rnd_read a=%0d cyc=%0d got=%h exp=%h", ra, n, spo, exp_rd); end
    end
    int_reply = 1'b0; i_irq = '0;
  endtask

  initial begin
    test_reset();
    test_edge_delivery();
    test_priority();
    test_level_withdraw();
    test_level_refire();
    test_timer_setwins();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
